// File: rtl/cursor_accel.sv
// rtl/cursor_accel.sv - joystick cursor position with per-axis acceleration and window clamping
// One cursor_axis per coordinate; the top only detects the cursor tick edge and merges moved.

module cursor_axis #(
  parameter int COORD_W     = 10,
  parameter int JOY_W       = 10,
  parameter int INIT        = 0,
  parameter int MIN         = 0,
  parameter int MAX         = 0,
  parameter int FAST_LO     = 150,
  parameter int DEAD_LO     = 400,
  parameter int DEAD_HI     = 600,
  parameter int FAST_HI     = 850,
  parameter int STEP_SLOW   = 10,
  parameter int STEP_FAST   = 20,
  parameter int ACCEL_TICKS = 4,
  parameter int ACCEL_MAX   = 2,
  parameter bit LOW_NEG     = 1'b0,
  parameter bit INV         = 1'b0
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               tick,
  input  logic               enable,
  input  logic               recenter,
  input  logic [JOY_W-1:0]   joy,
  output logic [COORD_W-1:0] pos,
  output logic               moved,
  output logic               at_lo,
  output logic               at_hi
);
  localparam int EW    = COORD_W + 2;
  localparam int LVL_W = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [JOY_W-1:0]      FL      = JOY_W'(FAST_LO);
  localparam logic [JOY_W-1:0]      DL      = JOY_W'(DEAD_LO);
  localparam logic [JOY_W-1:0]      DH      = JOY_W'(DEAD_HI);
  localparam logic [JOY_W-1:0]      FH      = JOY_W'(FAST_HI);
  localparam logic signed [EW-1:0]  MIN_E   = EW'(MIN);
  localparam logic signed [EW-1:0]  MAX_E   = EW'(MAX);
  localparam logic [COORD_W-1:0]    MIN_C   = COORD_W'(MIN);
  localparam logic [COORD_W-1:0]    MAX_C   = COORD_W'(MAX);
  localparam logic [COORD_W-1:0]    INIT_C  = COORD_W'(INIT);
  localparam logic [LVL_W-1:0]      LVL_TOP = LVL_W'(ACCEL_MAX);
  localparam logic [CNT_W-1:0]      CNT_TOP = CNT_W'(ACCEL_TICKS);

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                last_neg_q, last_neg_d;
  logic [COORD_W-1:0]  pos_q, pos_d;
  logic                moved_q, moved_d;
  logic                at_lo_q, at_lo_d;
  logic                at_hi_q, at_hi_d;

  logic                dir_none, low_side, fast, dir_neg, restart;
  logic [LVL_W-1:0]    lvl_cur;
  logic [CNT_W-1:0]    cnt_inc;
  logic signed [EW-1:0] base, step, pos_ext, sum;
  logic [COORD_W-1:0]  pos_new;

  always_comb begin
    dir_none = (joy >= DL) && (joy <= DH);
    low_side = joy < DL;
    fast     = (joy < FL) || (joy > FH);
    dir_neg  = (low_side ? LOW_NEG : ~LOW_NEG) ^ INV;
    // Starting from idle or reversing drops straight back to level 0 and counts this tick.
    restart  = (state_q == ST_IDLE) || (dir_neg != last_neg_q);
    lvl_cur  = restart ? '0 : level_q;
    cnt_inc  = restart ? CNT_W'(1) : count_q + CNT_W'(1);
    base     = fast ? EW'(STEP_FAST) : EW'(STEP_SLOW);
    step     = base << lvl_cur;
    pos_ext  = $signed({2'b00, pos_q});
    sum      = dir_neg ? (pos_ext - step) : (pos_ext + step);
    if (sum < MIN_E)      pos_new = MIN_C;
    else if (sum > MAX_E) pos_new = MAX_C;
    else                  pos_new = sum[COORD_W-1:0];

    state_d    = state_q;
    level_d    = level_q;
    count_d    = count_q;
    last_neg_d = last_neg_q;
    pos_d      = pos_q;
    moved_d    = 1'b0;
    if (recenter) begin
      state_d = ST_IDLE;
      level_d = '0;
      count_d = '0;
      pos_d   = INIT_C;
    end else if (!enable) begin
      state_d = ST_IDLE;
      level_d = '0;
      count_d = '0;
    end else if (tick) begin
      if (dir_none) begin
        state_d = ST_IDLE;
        level_d = '0;
        count_d = '0;
      end else begin
        state_d    = ST_ACC;
        last_neg_d = dir_neg;
        pos_d      = pos_new;
        moved_d    = pos_new != pos_q;
        if (cnt_inc == CNT_TOP) begin
          count_d = '0;
          level_d = (lvl_cur == LVL_TOP) ? lvl_cur : lvl_cur + LVL_W'(1);
        end else begin
          count_d = cnt_inc;
          level_d = lvl_cur;
        end
      end
    end
    at_lo_d = pos_d == MIN_C;
    at_hi_d = pos_d == MAX_C;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      count_q    <= '0;
      last_neg_q <= 1'b0;
      pos_q      <= INIT_C;
      moved_q    <= 1'b0;
      at_lo_q    <= (INIT == MIN);
      at_hi_q    <= (INIT == MAX);
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      count_q    <= count_d;
      last_neg_q <= last_neg_d;
      pos_q      <= pos_d;
      moved_q    <= moved_d;
      at_lo_q    <= at_lo_d;
      at_hi_q    <= at_hi_d;
    end
  end

  assign pos   = pos_q;
  assign moved = moved_q;
  assign at_lo = at_lo_q;
  assign at_hi = at_hi_q;
endmodule

module cursor_accel #(
  parameter int COORD_W     = 10,
  parameter int JOY_W       = 10,
  parameter int INIT_X      = 627,
  parameter int INIT_Y      = 271,
  parameter int X_MIN       = 566,
  parameter int X_MAX       = 689,
  parameter int Y_MIN       = 116,
  parameter int Y_MAX       = 426,
  parameter int FAST_LO     = 150,
  parameter int DEAD_LO     = 400,
  parameter int DEAD_HI     = 600,
  parameter int FAST_HI     = 850,
  parameter int STEP_SLOW   = 10,
  parameter int STEP_FAST   = 20,
  parameter int ACCEL_TICKS = 4,
  parameter int ACCEL_MAX   = 2,
  parameter int INV_X       = 0,
  parameter int INV_Y       = 0
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               clk_cursor,
  input  logic               enable,
  input  logic               recenter,
  input  logic [JOY_W-1:0]   joy_x,
  input  logic [JOY_W-1:0]   joy_y,
  output logic [COORD_W-1:0] dot_x,
  output logic [COORD_W-1:0] dot_y,
  output logic               moved,
  output logic               at_x_lo,
  output logic               at_x_hi,
  output logic               at_y_lo,
  output logic               at_y_hi
);
  logic prev_q, prev_d, tick, moved_x, moved_y;

  // prev resets high so a level already high at reset release is not taken as an edge.
  always_comb begin
    prev_d = clk_cursor;
    tick   = clk_cursor & ~prev_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  cursor_axis #(
    .COORD_W(COORD_W), .JOY_W(JOY_W), .INIT(INIT_X), .MIN(X_MIN), .MAX(X_MAX),
    .FAST_LO(FAST_LO), .DEAD_LO(DEAD_LO), .DEAD_HI(DEAD_HI), .FAST_HI(FAST_HI),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .ACCEL_TICKS(ACCEL_TICKS),
    .ACCEL_MAX(ACCEL_MAX), .LOW_NEG(1'b0), .INV(INV_X != 0)
  ) u_x (
    .clk(clk), .clr_n(clr_n), .tick(tick), .enable(enable), .recenter(recenter),
    .joy(joy_x), .pos(dot_x), .moved(moved_x), .at_lo(at_x_lo), .at_hi(at_x_hi)
  );

  cursor_axis #(
    .COORD_W(COORD_W), .JOY_W(JOY_W), .INIT(INIT_Y), .MIN(Y_MIN), .MAX(Y_MAX),
    .FAST_LO(FAST_LO), .DEAD_LO(DEAD_LO), .DEAD_HI(DEAD_HI), .FAST_HI(FAST_HI),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .ACCEL_TICKS(ACCEL_TICKS),
    .ACCEL_MAX(ACCEL_MAX), .LOW_NEG(1'b1), .INV(INV_Y != 0)
  ) u_y (
    .clk(clk), .clr_n(clr_n), .tick(tick), .enable(enable), .recenter(recenter),
    .joy(joy_y), .pos(dot_y), .moved(moved_y), .at_lo(at_y_lo), .at_hi(at_y_hi)
  );

  assign moved = moved_x | moved_y;
endmodule

// File: doc/cursor_accel.md
# cursor_accel

Joystick-driven cursor position register with per-axis acceleration and exact boundary clamping. It is the parametrised successor to the fixed-step cursor updater. It samples a slow cursor tick internally, classifies each joystick axis into direction and speed, grows the step size while a direction is held, and saturates the position inside a programmable window. It sits between the joystick SPI front end and the VGA sprite/overlay logic.

## Interface
Parameters:
- COORD_W, 10: width of dot_x/dot_y.
- JOY_W, 10: width of joy_x/joy_y (unsigned).
- INIT_X / INIT_Y, 627 / 271: position after reset or recenter; must lie inside the window.
- X_MIN / X_MAX, 566 / 689: inclusive x window.
- Y_MIN / Y_MAX, 116 / 426: inclusive y window.
- FAST_LO / DEAD_LO / DEAD_HI / FAST_HI, 150 / 400 / 600 / 850: joystick thresholds.
- STEP_SLOW / STEP_FAST, 10 / 20: base steps.
- ACCEL_TICKS, 4: consecutive same-direction ticks per acceleration level (≥1).
- ACCEL_MAX, 2: maximum level; step = base << level.
- INV_X / INV_Y, 0 / 0: invert axis sense.

Ports:
- clk, in, 1: system clock.
- clr_n, in, 1: asynchronous, active-low reset.
- clk_cursor, in, 1: slow cursor tick level, synchronous to clk; rising edge detected internally.
- enable, in, 1: movement enable.
- recenter, in, 1: synchronous load of INIT_X/INIT_Y.
- joy_x, joy_y, in, JOY_W: raw joystick samples.
- dot_x, dot_y, out, COORD_W: cursor position.
- moved, out, 1: one-cycle pulse when either coordinate changed.
- at_x_lo, at_x_hi, at_y_lo, at_y_hi, out, 1: registered, position equals the corresponding bound.

One clock; reset is asynchronous and active-low.

## Operation
- Tick: prev register holds clk_cursor. tick = clk_cursor & ~prev.
- Axis classification (INV=0), x: joy<FAST_LO gives +fast; joy<DEAD_LO gives +slow; DEAD_LO..DEAD_HI inclusive gives none; joy>FAST_HI gives -fast; otherwise -slow. y uses the same bands with the signs swapped: low values move -y (up), high values move +y. INV flips the sign.
- Per-axis acceleration FSM, states IDLE, ACC0..ACC{ACCEL_MAX}, with a hold counter:
  - A tick with dir=none, or a dir opposite the last dir, goes to IDLE. A reversal then moves immediately at level 0, so the state becomes ACC0 with count=1.
  - A tick with the same dir increments count. When count reaches ACCEL_TICKS, level goes up by 1 (saturating at ACCEL_MAX) and count clears.
  - A change of speed only (slow/fast) keeps the current level.
- Step = base << level, where level is the value before this tick's increment.
- Arithmetic: new = pos ± step, computed in COORD_W+2 bits signed, then clamped to [MIN, MAX]. There is no wrap or overshoot.
- enable=0: ticks are ignored, both FSMs are forced to IDLE, and position is held.
- Priority: clr_n, then recenter, then tick. recenter forces position to INIT, both FSMs to IDLE, and moved=0, even if a tick occurs in the same cycle.
- An axis already at a bound and pushed further does not change, and moved stays 0 for that axis. The FSM still advances.

## Timing
- Reset values: dot_x=INIT_X, dot_y=INIT_Y, moved=0, all at_* flags reflect INIT (0 with defaults), FSMs IDLE, counts 0, prev=1. Because prev=1, a clk_cursor held high through reset release produces no tick until it has been seen low.
- Position, moved, and at_* flags update on the same clk edge at which tick is true, and are visible the next cycle. Latency is 1 clk from the sampled rising edge.
- moved is high for exactly 1 clk per effective tick.
- Reset asserted mid-operation restores all reset values immediately (asynchronous). Release is synchronous to clk in the surrounding logic.

## Test plan
- Reset: hold clr_n low with clk_cursor=1, then release. Required: dot=(627,271), moved=0, flags 0. No movement until clk_cursor goes 0→1.
- Fast right with clamp: joy_x=100, joy_y=500, 3 ticks. Required: dot_x 647, 667, 687. 4th tick: 689 with at_x_hi=1 and moved=1. 5th tick: 689 with moved=0.
- Acceleration: joy_y=300, 9 ticks from 271. Required: 261, 251, 241, 231, 211, 191, 171, 151, then 116 (clamped) with at_y_lo=1.
- Reversal: after reaching level 2 upward, set joy_y=700 and tick. Required: dot_y +10 (level reset to 0).
- Dead zone and enable: joy=(500,500) ticks leave the position unchanged with moved=0. joy_x=100 with enable=0 leaves it unchanged. Re-enabling gives a step of 20, not an accelerated step.
- Recenter collision: recenter=1 in the same cycle as a tick at dot=(689,116). Required: next cycle dot=(627,271), moved=0, and the next tick moves at level 0.
